// File: rtl/acc_arb_pkg.sv
// Shared types and limits for the accelerator request arbiter.
// Payload structs are sized from the defaults below; the arbiter takes them as type parameters.
package acc_arb_pkg;

    localparam int unsigned ACC_ARB_MAX_REQ       = 16;
    localparam int unsigned ACC_ARB_XLEN          = 64;
    localparam int unsigned ACC_ARB_TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [31:0]                      insn;
        logic [ACC_ARB_XLEN-1:0]          rs1;
        logic [ACC_ARB_XLEN-1:0]          rs2;
        logic [ACC_ARB_TRANS_ID_BITS-1:0] trans_id;
    } acc_arb_req_t;

    typedef struct packed {
        logic [ACC_ARB_XLEN-1:0]          result;
        logic [ACC_ARB_TRANS_ID_BITS-1:0] trans_id;
    } acc_arb_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with occupancy reporting; holds arbiter routing indices.
// Optional fall-through mode forwards data_i while empty.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    dtype                  mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  is_full, is_empty, bypass, do_write;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign is_full  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
    assign is_empty = (cnt_q == '0);
    assign bypass   = FALL_THROUGH && is_empty && push_i && pop_i;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        do_write = 1'b0;
        if (push_i && !is_full && !bypass) begin
            do_write = 1'b1;
            wptr_d   = ptr_inc(wptr_q);
            cnt_d    = cnt_d + 1'b1;
        end
        if (pop_i && !is_empty) begin
            rptr_d = ptr_inc(rptr_q);
            cnt_d  = cnt_d - 1'b1;
        end
        if (flush_i) begin
            wptr_d   = '0;
            rptr_d   = '0;
            cnt_d    = '0;
            do_write = 1'b0;
        end
    end

    assign full_o  = is_full;
    assign empty_o = is_empty && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && is_empty) ? data_i : mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage has no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator port among NrReq requesters.
// Granted indices are queued so in-order responses return to their issuer.
module acc_req_arbiter
    import acc_arb_pkg::*;
#(
    parameter int unsigned NrReq          = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TransIdWidth   = ACC_ARB_TRANS_ID_BITS,
    parameter int unsigned XLEN           = ACC_ARB_XLEN,
    parameter type         req_t          = acc_arb_req_t,
    parameter type         resp_t         = acc_arb_resp_t
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrReq-1:0]                    req_valid_i,
    output logic [NrReq-1:0]                    req_ready_o,
    input  req_t [NrReq-1:0]                    req_i,
    output logic                                acc_req_valid_o,
    input  logic                                acc_req_ready_i,
    output req_t                                acc_req_o,
    input  logic                                acc_resp_valid_i,
    output logic                                acc_resp_ready_o,
    input  resp_t                               acc_resp_i,
    output logic [NrReq-1:0]                    resp_valid_o,
    input  logic [NrReq-1:0]                    resp_ready_i,
    output resp_t                               resp_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                err_o
);

    localparam int unsigned IdxW  = $clog2(NrReq);
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned AddrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef logic [IdxW-1:0] idx_t;

    if (NrReq < 2 || NrReq > ACC_ARB_MAX_REQ || MaxOutstanding < 1 ||
        XLEN < 1 || TransIdWidth < 1) begin : g_param_check
        $error("acc_req_arbiter: unsupported parameter set");
    end

    idx_t             rr_q, rr_d, lock_idx_q, lock_idx_d;
    idx_t             arb_idx, gnt_idx, head_idx;
    logic             lock_q, lock_d, err_q, err_d;
    logic             arb_found, handshake, pop;
    logic             q_full, q_empty, q_rst_n;
    logic [AddrW-1:0] q_usage;
    int unsigned      cand;

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        arb_idx   = rr_q;
        arb_found = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            cand = (int'(rr_q) + k) % NrReq;
            if (!arb_found && req_valid_i[idx_t'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = idx_t'(cand);
            end
        end
    end

    assign gnt_idx         = lock_q ? lock_idx_q : arb_idx;
    assign acc_req_valid_o = ~rst_i & (|req_valid_i) & ~q_full;
    assign handshake       = acc_req_valid_o & acc_req_ready_i;
    assign acc_req_o       = rst_i ? '0 : req_i[gnt_idx];

    assign acc_resp_ready_o = q_empty | resp_ready_i[head_idx];
    assign pop              = ~q_empty & acc_resp_valid_i & resp_ready_i[head_idx];
    assign resp_o           = rst_i ? '0 : acc_resp_i;

    for (genvar gi = 0; gi < NrReq; gi++) begin : g_port
        assign req_ready_o[gi]  = handshake & (gnt_idx == idx_t'(gi));
        assign resp_valid_o[gi] = ~q_empty & acc_resp_valid_i & (head_idx == idx_t'(gi));
    end

    always_comb begin
        rr_d       = handshake ? ((gnt_idx == idx_t'(NrReq - 1)) ? '0 : gnt_idx + 1'b1) : rr_q;
        lock_d     = acc_req_valid_o & ~acc_req_ready_i;
        lock_idx_d = gnt_idx;
        err_d      = err_q | (q_empty & acc_resp_valid_i);
    end

    assign q_rst_n = ~rst_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (MaxOutstanding),
        .dtype        (idx_t)
    ) i_route_q (
        .clk_i   (clk_i),
        .rst_ni  (q_rst_n),
        .flush_i (1'b0),
        .full_o  (q_full),
        .empty_o (q_empty),
        .usage_o (q_usage),
        .data_i  (gnt_idx),
        .push_i  (handshake),
        .data_o  (head_idx),
        .pop_i   (pop)
    );

    // usage_o wraps to zero when the queue is exactly full.
    assign outstanding_o = q_full ? CntW'(MaxOutstanding) : CntW'(q_usage);
    assign err_o         = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    lock_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
        lock_q |-> req_valid_i[lock_idx_q]);

endmodule
